// File: rtl/bus_master_if.sv
// Bus master interface: request side, arbiter handshake and bit-serial bus.
interface bus_master_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    // Request side
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    // Arbiter
    logic                  breq;
    logic                  bgrant;
    // Serial bus
    logic                  m_valid;
    logic                  m_mode;
    logic                  m_wdata;
    logic                  s_ready;
    logic                  s_rvalid;
    logic                  s_rdata;

    modport master (
        input  start, mode, addr, wdata, bgrant, s_ready, s_rvalid, s_rdata,
        output rdata, busy, done, err, breq, m_valid, m_mode, m_wdata
    );

    modport slave (
        output start, mode, addr, wdata, bgrant, s_ready, s_rvalid, s_rdata,
        input  rdata, busy, done, err, breq, m_valid, m_mode, m_wdata
    );
endinterface

// File: rtl/bus_master.sv
// Bit-serial system-bus master: one read or write transaction per start pulse.
// Requests the bus, shifts address (and write data) out LSB first, then waits
// for the write acknowledge or collects serial read data.
// Optional feature: define BUS_MASTER_TIMEOUT_EN to bound the REQ/WACK/RDATA
// waits by TIMEOUT cycles and report an expired wait on err.
module bus_master #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rstn,
    bus_master_if.master bus
);
    localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam int unsigned SH_W  = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_WACK  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Reject parameter sets the datapath cannot represent
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("bus_master: unsupported ADDR_WIDTH/DATA_WIDTH/TIMEOUT");
    end

    logic [2:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [SH_W-1:0]       sh_q,      sh_d;       // {wdata, addr}, shifted out LSB first
    logic                  mode_q,    mode_d;
    logic [DATA_WIDTH-2:0] rd_sh_q,   rd_sh_d;    // read bits collected so far
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  breq_q,    breq_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_mode_q,  m_mode_d;
    logic                  m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] rd_cat;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]       wcnt_q,    wcnt_d;
    logic                  err_q,     err_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            mode_q    <= 1'b0;
            rd_sh_q   <= '0;
            rdata_q   <= '0;
            breq_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_mode_q  <= 1'b0;
            m_wdata_q <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            wcnt_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            mode_q    <= mode_d;
            rd_sh_q   <= rd_sh_d;
            rdata_q   <= rdata_d;
            breq_q    <= breq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_valid_q <= m_valid_d;
            m_mode_q  <= m_mode_d;
            m_wdata_q <= m_wdata_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next state, datapath and next-cycle output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        mode_d    = mode_q;
        rd_sh_d   = rd_sh_q;
        rdata_d   = rdata_q;
        m_wdata_d = 1'b0;
        rd_cat    = {bus.s_rdata, rd_sh_q};
`ifdef BUS_MASTER_TIMEOUT_EN
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_REQ;
                    mode_d  = bus.mode;
                    sh_d    = {bus.wdata, bus.addr};
                end
            end
            S_REQ: begin
                if (bus.bgrant) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                    state_d = mode_q ? S_WDATA : S_RDATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WDATA: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = S_WACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WACK: begin
                if (bus.s_ready) begin
                    state_d = S_DONE;
                end
            end
            S_RDATA: begin
                if (bus.s_rvalid) begin
                    rd_sh_d = rd_cat[DATA_WIDTH-1:1];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        rdata_d = rd_cat;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BUS_MASTER_TIMEOUT_EN
        // Bound the waits; a valid read bit restarts the RDATA wait
        if (state_d != state_q) begin
            wcnt_d = '0;
        end else if (state_q == S_REQ || state_q == S_WACK || state_q == S_RDATA) begin
            if (state_q == S_RDATA && bus.s_rvalid) begin
                wcnt_d = '0;
            end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                wcnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + TO_W'(1);
            end
        end
`endif

        // Bit counter restarts on every state entry
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        breq_d    = (state_d == S_REQ)   || (state_d == S_ADDR) || (state_d == S_WDATA) ||
                    (state_d == S_WACK)  || (state_d == S_RDATA);
        busy_d    = (state_d != S_IDLE);
`ifdef BUS_MASTER_TIMEOUT_EN
        busy_d    = busy_d || err_d;
`endif
        done_d    = (state_d == S_DONE);
        m_valid_d = (state_d == S_ADDR) || (state_d == S_WDATA);
        m_mode_d  = breq_d ? mode_d : 1'b0;

        if (m_valid_d) begin
            m_wdata_d = sh_q[0];
            sh_d      = sh_q >> 1;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.breq    = breq_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_mode  = m_mode_q;
    assign bus.m_wdata = m_wdata_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// Testbench for bus_master: directed scenarios plus randomized transactions,
// checked against a transaction-level model of the bus protocol.
module tb_bus_master;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 20;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    logic [DW-1:0] model_rdata;

    bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.bgrant   = 1'b0;
        bus.s_ready  = 1'b0;
        bus.s_rvalid = 1'b0;
        bus.s_rdata  = 1'b0;
    endtask

    // One transaction: drives request, arbiter and slave, checks every cycle.
    // ack_delay < 0 means the slave never acknowledges (timeout expected).
    // gap_mode: 0 none, 1 two idle cycles between read bits 3 and 4, 2 random.
    task automatic run_txn(input logic md, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rv, input int gdelay, input int ack_delay,
                           input int gap_mode, input bit extra_start, input string name);
        int n, grant_cyc, vcnt, last_bit, last_addr, sent, exp_end, gap_left;
        bit finished, expect_err, give;
        logic term;
        logic [AW+DW-1:0] stream;
        n = 0; grant_cyc = -1; vcnt = 0; last_bit = -1; last_addr = -1; sent = 0;
        exp_end = -1; gap_left = 2; finished = 1'b0; stream = '0;
        expect_err = md && (ack_delay < 0);

        bus.start = 1'b1; bus.mode = md; bus.addr = a; bus.wdata = wd;
        bus.bgrant = (gdelay == 0); bus.s_ready = 1'b0; bus.s_rvalid = 1'b0;
        tick();
        n = 1;
        bus.start = 1'b0; bus.mode = ~md; bus.addr = AW'($urandom); bus.wdata = DW'($urandom);

        while (!finished && n < 400) begin
            n_tests++;
            if (bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL %s busy@%0d: got %b want 1", name, n, bus.busy);
            end
            if (!expect_err) begin
                n_tests++;
                if (bus.err !== 1'b0) begin
                    n_fail++; $display("FAIL %s err@%0d: got %b want 0", name, n, bus.err);
                end
            end else begin
                n_tests++;
                if (bus.done !== 1'b0) begin
                    n_fail++; $display("FAIL %s done_in_timeout@%0d: got %b want 0", name, n, bus.done);
                end
            end
            term = expect_err ? bus.err : bus.done;
            if (term === 1'b1) begin
                finished = 1'b1;
                n_tests++;
                if (n !== exp_end) begin
                    n_fail++; $display("FAIL %s end_cycle: got %0d want %0d", name, n, exp_end);
                end
                n_tests++;
                if (bus.breq !== 1'b0 || bus.m_valid !== 1'b0) begin
                    n_fail++; $display("FAIL %s end_breq_mvalid: got %b%b want 00", name, bus.breq, bus.m_valid);
                end
                n_tests++;
                if (vcnt !== (md ? AW + DW : AW)) begin
                    n_fail++; $display("FAIL %s mvalid_count: got %0d want %0d", name, vcnt, md ? AW + DW : AW);
                end
                n_tests++;
                if (stream[AW-1:0] !== a) begin
                    n_fail++; $display("FAIL %s addr_stream: got %h want %h", name, stream[AW-1:0], a);
                end
                if (md) begin
                    n_tests++;
                    if (stream[AW+DW-1:AW] !== wd) begin
                        n_fail++; $display("FAIL %s data_stream: got %h want %h", name, stream[AW+DW-1:AW], wd);
                    end
                end
                if (!md) model_rdata = rv;
                n_tests++;
                if (bus.rdata !== model_rdata) begin
                    n_fail++; $display("FAIL %s rdata_at_end: got %h want %h", name, bus.rdata, model_rdata);
                end
                if (md && gdelay == 0 && ack_delay == 0) begin
                    n_tests++;
                    if (n !== 3 + AW + DW) begin
                        n_fail++; $display("FAIL %s min_latency: got %0d want %0d", name, n, 3 + AW + DW);
                    end
                end
            end else begin
                n_tests++;
                if (bus.breq !== 1'b1 || bus.m_mode !== md) begin
                    n_fail++; $display("FAIL %s breq_mmode@%0d: got %b%b want 1%b", name, n, bus.breq, bus.m_mode, md);
                end
                if (bus.m_valid === 1'b1) begin
                    if (vcnt == 0) begin
                        n_tests++;
                        if (n !== grant_cyc + 1) begin
                            n_fail++; $display("FAIL %s first_bit_cycle: got %0d want %0d", name, n, grant_cyc + 1);
                        end
                    end
                    if (vcnt < AW + DW) stream[vcnt] = bus.m_wdata;
                    vcnt++;
                    if (md && vcnt == AW + DW) last_bit = n;
                    if (!md && vcnt == AW) last_addr = n;
                end
                // Arbiter and request drive for this cycle
                bus.bgrant = (n - 1 >= gdelay);
                if (bus.bgrant && grant_cyc < 0) grant_cyc = n;
                bus.start = extra_start && (vcnt == 3);
                // Slave drive for this cycle
                if (md) begin
                    bus.s_rvalid = 1'($urandom);
                    bus.s_rdata  = 1'($urandom);
                    if (last_bit < 0) begin
                        bus.s_ready = 1'($urandom);
                    end else if (ack_delay >= 0 && n >= last_bit + 1 + ack_delay) begin
                        bus.s_ready = 1'b1;
                        if (exp_end < 0) exp_end = n + 1;
                    end else begin
                        bus.s_ready = 1'b0;
                    end
                    if (expect_err && last_bit >= 0 && exp_end < 0) exp_end = last_bit + 1 + TO;
                end else begin
                    bus.s_ready = 1'($urandom);
                    if (last_addr < 0 || n == last_addr) begin
                        bus.s_rvalid = 1'($urandom);
                        bus.s_rdata  = 1'($urandom);
                    end else if (sent < DW) begin
                        give = 1'b1;
                        if (gap_mode == 1 && sent == 4 && gap_left > 0) begin
                            give = 1'b0; gap_left--;
                        end
                        if (gap_mode == 2) give = ($urandom_range(0, 2) != 0);
                        if (give) begin
                            bus.s_rvalid = 1'b1;
                            bus.s_rdata  = rv[sent];
                            sent++;
                            if (sent == DW) exp_end = n + 1;
                        end else begin
                            bus.s_rvalid = 1'b0;
                            bus.s_rdata  = 1'($urandom);
                        end
                    end else begin
                        bus.s_rvalid = 1'b0;
                    end
                end
                tick();
                n++;
            end
        end
        if (!finished) begin
            n_tests++; n_fail++;
            $display("FAIL %s no_completion: got none within %0d cycles want completion", name, n);
        end
        idle_inputs();
        tick();
        // First cycle after completion: idle and ready for a new start
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.breq !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_end busy/done/breq/err: got %b%b%b%b want 0000", name,
                     bus.busy, bus.done, bus.breq, bus.err);
        end
        n_tests++;
        if (bus.rdata !== model_rdata) begin
            n_fail++; $display("FAIL %s rdata_hold: got %h want %h", name, bus.rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        tick(); tick();
        n_tests++;
        if ({bus.breq, bus.busy, bus.done, bus.err, bus.m_valid, bus.m_mode, bus.m_wdata} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000000",
                {bus.breq, bus.busy, bus.done, bus.err, bus.m_valid, bus.m_mode, bus.m_wdata});
        end
        n_tests++;
        if (bus.rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
        end
        rstn = 1'b1;
        model_rdata = '0;
        tick();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 16'h0012, 8'hA5, 8'h00, 0, 3, 0, 1'b0, "write");
        run_txn(1'b1, 16'h8001, 8'h5A, 8'h00, 0, 0, 0, 1'b0, "write_min");
    endtask

    task automatic test_read_gaps();
        run_txn(1'b0, 16'h0032, 8'h00, 8'h3C, 0, 0, 1, 1'b0, "read_gaps");
        run_txn(1'b1, 16'hFFFF, 8'hFF, 8'h00, 1, 1, 0, 1'b0, "write_keeps_rdata");
    endtask

    task automatic test_delayed_grant();
        run_txn(1'b0, 16'h1234, 8'h00, 8'hC3, 10, 0, 0, 1'b0, "delayed_grant_rd");
        run_txn(1'b1, 16'h4321, 8'h96, 8'h00, 10, 2, 0, 1'b0, "delayed_grant_wr");
    endtask

    task automatic test_busy_reject();
        run_txn(1'b1, 16'h0F0F, 8'h81, 8'h00, 0, 1, 0, 1'b1, "busy_reject");
    endtask

    task automatic test_reset_mid_read();
        int n, vcnt, last_addr, sent;
        n = 1; vcnt = 0; last_addr = -1; sent = 0;
        bus.bgrant = 1'b1; bus.start = 1'b1; bus.mode = 1'b0; bus.addr = 16'hBEEF;
        tick();
        bus.start = 1'b0;
        while (sent < 4 && n < 200) begin
            if (bus.m_valid === 1'b1) begin
                vcnt++;
                if (vcnt == AW) last_addr = n;
            end
            if (last_addr >= 0 && n > last_addr) begin
                bus.s_rvalid = 1'b1; bus.s_rdata = 1'($urandom); sent++;
            end else begin
                bus.s_rvalid = 1'b0;
            end
            tick();
            n++;
        end
        bus.s_rvalid = 1'b0;
        n_tests++;
        if (sent < 4 || bus.breq !== 1'b1 || bus.rdata !== model_rdata) begin
            n_fail++; $display("FAIL rst_mid_pre: got sent=%0d breq=%b rdata=%h want 4 1 %h",
                               sent, bus.breq, bus.rdata, model_rdata);
        end
        rstn = 1'b0;
        #1;
        model_rdata = '0;
        n_tests++;
        if ({bus.breq, bus.busy, bus.done, bus.m_valid, bus.m_mode} !== 5'b0 || bus.rdata !== '0) begin
            n_fail++; $display("FAIL rst_mid_immediate: got %b rdata=%h want 00000 rdata=0",
                {bus.breq, bus.busy, bus.done, bus.m_valid, bus.m_mode}, bus.rdata);
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_hold: got done=%b busy=%b want 0 0", bus.done, bus.busy);
            end
        end
        rstn = 1'b1;
        tick();
        run_txn(1'b0, 16'h00A0, 8'h00, 8'h69, 0, 0, 0, 1'b0, "after_reset_read");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 16'h5555, 8'h0F, 8'h00, 0, 0, 0, 1'b0, "b2b_first");
        run_txn(1'b0, 16'hAAAA, 8'h00, 8'hE1, 0, 0, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 2, 1'($urandom), "random");
        end
    endtask

`ifdef BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b1, 16'h7777, 8'h3E, 8'h00, 2, -1, 0, 1'b0, "timeout_wack");
        run_txn(1'b0, 16'h0101, 8'h00, 8'h5B, 0, 0, 2, 1'b0, "after_timeout_read");
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_rdata = '0;
        idle_inputs();
        test_reset();
        test_write();
        test_read_gaps();
        test_delayed_grant();
        test_busy_reject();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
`ifdef BUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
